// File: rtl/stream_strip_if.sv
// Handshake bundle for stream_strip: input stream, output stream, strip command
// and drop reporting. The block sits on the slave modport.
interface stream_strip_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD/8,
    parameter int CNT_WD       = 5
);
    logic                    valid_in;
    logic                    ready_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;

    logic                    valid_out;
    logic                    ready_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;

    logic                    valid_remove;
    logic                    ready_remove;
    logic [CNT_WD-1:0]       byte_remove_cnt;

    logic                    pkt_dropped;
    logic [15:0]             drop_cnt;

    modport slave (
        input  valid_in, data_in, keep_in, last_in, ready_out,
               valid_remove, byte_remove_cnt,
        output ready_in, valid_out, data_out, keep_out, last_out,
               ready_remove, pkt_dropped, drop_cnt
    );

    modport master (
        output valid_in, data_in, keep_in, last_in, ready_out,
               valid_remove, byte_remove_cnt,
        input  ready_in, valid_out, data_out, keep_out, last_out,
               ready_remove, pkt_dropped, drop_cnt
    );
endinterface

// File: rtl/stream_strip.sv
// Strips a per-packet number of leading bytes from a byte-keyed stream,
// realigning the remainder to beat boundaries with one beat of latency.
module stream_strip #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD/8,
    parameter int MAX_REMOVE   = 16,
    parameter int CNT_WD       = $clog2(MAX_REMOVE+1)
) (
    input logic           clk,
    input logic           rstn,
    stream_strip_if.slave s
);
    localparam int W    = DATA_BYTE_WD;
    localparam int R_WD = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, FLUSH} state_t;

    state_t              state;
    logic [CNT_WD-1:0]   rem;
    logic [R_WD-1:0]     r;
    logic [DATA_WD-1:0]  h_data;
    logic [W-1:0]        h_keep;
    logic                hvalid;
    logic [15:0]         drop_cnt_q;
    logic                pkt_dropped_q;

    logic [CNT_WD-1:0]   rem_cmd;
    logic [CNT_WD-1:0]   rem_next;
    logic [DATA_WD-1:0]  lo_data;
    logic [W-1:0]        lo_keep;
    logic [2*DATA_WD-1:0] cat;
    logic [2*W-1:0]      kcat;
    logic                tail_valid;
    logic                in_fire;
    logic                drop;

    assign rem_cmd  = (s.byte_remove_cnt > CNT_WD'(MAX_REMOVE)) ? CNT_WD'(MAX_REMOVE)
                                                                : s.byte_remove_cnt;
    assign rem_next = rem - CNT_WD'(W);

    // FLUSH drains the holding register against an all-zero next beat
    assign lo_data = (state == FLUSH) ? '0 : s.data_in;
    assign lo_keep = (state == FLUSH) ? '0 : s.keep_in;
    assign cat     = {h_data, lo_data};
    assign kcat    = {h_keep, lo_keep};

    assign s.data_out = DATA_WD'(cat >> (DATA_WD - 8*int'(r)));
    assign s.keep_out = W'(kcat >> (W - int'(r)));

    // keep is MSB-contiguous, so "more than r valid bytes" == byte r is valid
    always_comb begin
        tail_valid = 1'b0;
        for (int i = 0; i < W; i++)
            if (R_WD'(i) == r) tail_valid = s.keep_in[W-1-i];
    end

    assign s.ready_remove = (state == IDLE);
    assign s.ready_in     = (state == SKIP) || ((state == SHIFT) && (!hvalid || s.ready_out));
    assign s.valid_out    = ((state == SHIFT) && hvalid && s.valid_in) || (state == FLUSH);
    assign s.last_out     = ((state == SHIFT) && hvalid && s.last_in && !tail_valid) ||
                            (state == FLUSH);
    assign s.pkt_dropped  = pkt_dropped_q;
    assign s.drop_cnt     = drop_cnt_q;

    assign in_fire = s.valid_in && s.ready_in;
    assign drop    = in_fire && s.last_in &&
                     ((state == SKIP) || ((state == SHIFT) && !hvalid && !tail_valid));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            rem           <= '0;
            r             <= '0;
            h_data        <= '0;
            h_keep        <= '0;
            hvalid        <= 1'b0;
            drop_cnt_q    <= '0;
            pkt_dropped_q <= 1'b0;
        end else begin
            pkt_dropped_q <= drop;
            if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            case (state)
                IDLE: if (s.valid_remove) begin
                    rem    <= rem_cmd;
                    r      <= R_WD'(rem_cmd);
                    h_data <= '0;
                    h_keep <= '0;
                    hvalid <= 1'b0;
                    state  <= (int'(rem_cmd) >= W) ? SKIP : SHIFT;
                end
                SKIP: if (in_fire) begin
                    rem <= rem_next;
                    if (s.last_in) begin
                        state <= IDLE;
                    end else if (int'(rem) < 2*W) begin
                        state  <= SHIFT;
                        r      <= R_WD'(rem_next);
                        h_data <= '0;
                        h_keep <= '0;
                        hvalid <= 1'b0;
                    end
                end
                SHIFT: if (in_fire) begin
                    h_data <= s.data_in;
                    h_keep <= s.keep_in;
                    hvalid <= 1'b1;
                    if (s.last_in) state <= tail_valid ? FLUSH : IDLE;
                end
                FLUSH: if (s.ready_out) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/stream_strip.md
STREAM_STRIP -- requirements
Module: stream_strip

Interface
REQ-001 SHALL have parameter DATA_WD, default 32: data width in bits, a multiple of 8.
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8: bytes per beat (W).
REQ-003 SHALL have parameter MAX_REMOVE, default 16: largest head-strip count in bytes (may exceed W).
REQ-004 SHALL have parameter CNT_WD, default $clog2(MAX_REMOVE+1): width of the strip count.
REQ-005 SHALL have ports: clk input 1, the clock; rstn input 1, reset, asynchronous, active-low.
REQ-006 SHALL have input port valid_in (1), data_in (DATA_WD), keep_in (DATA_BYTE_WD) and last_in (1), plus output ready_in (1): the input stream.
REQ-007 SHALL have output port valid_out (1), data_out (DATA_WD), keep_out (DATA_BYTE_WD) and last_out (1), plus input ready_out (1): the output stream.
REQ-008 SHALL have input valid_remove (1), input byte_remove_cnt (CNT_WD) and output ready_remove (1): the per-packet strip command.
REQ-009 SHALL have outputs pkt_dropped (1), a one-cycle pulse, and drop_cnt (16), a saturating count of dropped packets.

Function
REQ-010 Byte 0 of a beat SHALL be data[DATA_WD-1 -: 8], qualified by keep[DATA_BYTE_WD-1]; keep_in is MSB-contiguous, and only the last beat may be partial.
REQ-011 A transfer SHALL fire on valid && ready; valid_out, once high, holds data, keep and last stable until it fires.
REQ-012 The FSM SHALL have states IDLE, SKIP, SHIFT and FLUSH; ready_remove = (state==IDLE).
REQ-013 Command fire in IDLE SHALL latch rem = min(byte_remove_cnt, MAX_REMOVE) and enter SKIP when rem >= W, else SHIFT with r = rem.
REQ-014 In SKIP, ready_in SHALL be 1 and valid_out 0; each input fire subtracts W from rem.
REQ-015 In SKIP, an input fire with rem-W < W and !last_in SHALL enter SHIFT with r = rem-W.
REQ-016 In SKIP, a fire with last_in SHALL pulse pkt_dropped, increment drop_cnt and return to IDLE.
REQ-017 Holding register H (data, keep, hvalid) SHALL be cleared on entry to SHIFT.
REQ-018 In SHIFT, ready_in SHALL be !hvalid || ready_out, and valid_out SHALL be hvalid && valid_in (combinational).
REQ-019 data_out and keep_out SHALL be bytes [r, r+W) of {H, data_in} and {H.keep, keep_in}; every input fire loads H and sets hvalid.
REQ-020 In SHIFT with hvalid, a last_in beat carrying n valid bytes SHALL assert last_out and return to IDLE when n <= r; when n > r, last_out SHALL be 0 and the FSM SHALL enter FLUSH.
REQ-021 In SHIFT with !hvalid (first beat), a last_in fire with n > r SHALL enter FLUSH; with n <= r it SHALL drop the packet as in REQ-016.
REQ-022 FLUSH SHALL hold ready_in = 0 and valid_out = 1, with data and keep = bytes [r, r+W) of {H, zeros} and last_out = 1; on fire the FSM returns to IDLE.
REQ-023 drop_cnt SHALL saturate at 16'hFFFF; a strip count larger than the packet SHALL never produce output beats.
REQ-024 Throughput SHALL be one beat per cycle in SHIFT under no backpressure; latency SHALL be one input beat.
REQ-025 valid_in in IDLE SHALL be ignored (ready_in = 0); a new command SHALL NOT be accepted mid-packet.

Reset
REQ-026 Under rstn low, the block SHALL go to state IDLE with hvalid, H, rem, r and drop_cnt at 0.
REQ-027 Under rstn low, valid_out, last_out, pkt_dropped and ready_in SHALL be 0, and ready_remove SHALL be 1.
REQ-028 Reset mid-packet SHALL abandon the packet without emitting further beats.

Verification (DATA_WD=32, W=4)
REQ-029 cnt=2; 3 full beats of bytes 00..0B -> out {02030405}, {06070809}, then {0A0B,keep 1100,last}.
REQ-030 cnt=6; beats 00..03 and 04..07 with last -> one beat {06,07}, keep 1100, last_out=1.
REQ-031 cnt=5; single beat keep 1111 with last -> no valid_out, pkt_dropped pulse, drop_cnt=1.
REQ-032 cnt=0; 2 beats, last keep 1000 -> identical beats out, one beat late, last keep 1000.
REQ-033 cnt=1; ready_out low 3 cycles mid-packet -> valid_out and data held stable, ready_in=0, no byte lost or duplicated.
REQ-034 rstn pulsed during SHIFT -> valid_out=0 next cycle, ready_remove=1, and a following packet with cnt=0 passes intact.
